// File: rtl/apb_arbiter_if.sv
// Bundle of the upstream requester buses and the downstream APB3 completer bus
// seen by apb_arbiter. "master" is the arbiter's view; "slave" is its environment.
interface apb_arbiter_if #(
  parameter int NUM_MASTERS    = 2,
  parameter int APB_ADDR_WIDTH = 32
);
  // Upstream requester side
  logic [NUM_MASTERS-1:0]                m_psel_i;
  logic [NUM_MASTERS-1:0]                m_penable_i;
  logic [NUM_MASTERS-1:0]                m_pwrite_i;
  logic [NUM_MASTERS*APB_ADDR_WIDTH-1:0] m_paddr_i;
  logic [NUM_MASTERS*32-1:0]             m_pwdata_i;
  logic [31:0]                           m_prdata_o;
  logic [NUM_MASTERS-1:0]                m_pready_o;
  logic [NUM_MASTERS-1:0]                m_pslverr_o;

  // Downstream completer side
  logic                                  PSEL;
  logic                                  PENABLE;
  logic                                  PWRITE;
  logic [APB_ADDR_WIDTH-1:0]             PADDR;
  logic [31:0]                           PWDATA;
  logic [31:0]                           PRDATA;
  logic                                  PREADY;
  logic                                  PSLVERR;

  // Status
  logic [NUM_MASTERS-1:0]                grant_o;
  logic                                  timeout_o;

  modport master (
    input  m_psel_i, m_penable_i, m_pwrite_i, m_paddr_i, m_pwdata_i,
    output m_prdata_o, m_pready_o, m_pslverr_o,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR,
    output grant_o, timeout_o
  );

  modport slave (
    output m_psel_i, m_penable_i, m_pwrite_i, m_paddr_i, m_pwdata_i,
    input  m_prdata_o, m_pready_o, m_pslverr_o,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR,
    input  grant_o, timeout_o
  );
endinterface

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB3 completer between NUM_MASTERS requesters.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           ACLK,
  input logic           ARESETn,
  apb_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          last_q, last_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  logic [NUM_MASTERS-1:0]    grant_q, grant_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;

  logic                      req_any;
  logic [IDX_W-1:0]          winner;
  logic                      in_access;
  logic                      timeout_hit;
  logic                      complete;

  // PENABLE from requesters carries no information the arbiter needs.
  logic unused_penable;
  assign unused_penable = ^bus.m_penable_i;

  assign in_access = (state_q == ACCESS);

  // Search from last+1 upward with wrap; iterating from the far end down lets
  // the closest requester overwrite any farther match.
  always_comb begin
    winner  = '0;
    req_any = 1'b0;
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      if (bus.m_psel_i[(int'(last_q) + off) % NUM_MASTERS]) begin
        winner  = IDX_W'((int'(last_q) + off) % NUM_MASTERS);
        req_any = 1'b1;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == SETUP) begin
      tmo_cnt_d = '0;
    end else if (in_access && !bus.PREADY) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // The counter holds the number of earlier stalled ACCESS cycles, so the limit
  // is reached in the cycle that would be stalled cycle number TIMEOUT_CYCLES.
  assign timeout_hit = in_access && !bus.PREADY &&
                       (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign complete = in_access && (bus.PREADY || timeout_hit);

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch instead of combinational logic.
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;

    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d  = SETUP;
          owner_d  = winner;
          grant_d  = NUM_MASTERS'(1) << winner;
          paddr_d  = bus.m_paddr_i[int'(winner)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
          pwdata_d = bus.m_pwdata_i[int'(winner)*32 +: 32];
          pwrite_d = bus.m_pwrite_i[winner];
          psel_d   = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (complete) begin
          state_d   = IDLE;
          last_d    = owner_q;
          grant_d   = '0;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        grant_d   = '0;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of statement order.
    if (!ARESETn) begin
      state_q   <= IDLE;
      last_q    <= LAST_RST;
      owner_q   <= '0;
      grant_q   <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.grant_o = grant_q;

  // Completion is routed to the owner only; a timeout reports as an error.
  assign bus.m_pready_o  = complete ? grant_q : '0;
  assign bus.m_pslverr_o = complete ? (grant_q & {NUM_MASTERS{bus.PSLVERR | timeout_hit}})
                                    : '0;
  assign bus.m_prdata_o  = bus.PRDATA;
  assign bus.timeout_o   = timeout_hit;

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_apb_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic ACLK = 1'b0;
  logic ARESETn;
  int   checks = 0;
  int   errors = 0;

  apb_arbiter_if #(.NUM_MASTERS(N), .APB_ADDR_WIDTH(AW)) bus ();

  apb_arbiter #(
    .NUM_MASTERS   (N),
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ACLK   (ACLK),
    .ARESETn(ARESETn),
    .bus    (bus)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: outstanding request per requester plus last owner.
  int          last_owner;
  bit          pending [N];
  logic [31:0] r_addr  [N];
  logic [31:0] r_data  [N];
  logic        r_wr    [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic post_req(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input logic wr);
    r_addr[m]  = addr;
    r_data[m]  = data;
    r_wr[m]    = wr;
    pending[m] = 1'b1;
    bus.m_psel_i[m]            = 1'b1;
    bus.m_pwrite_i[m]          = wr;
    bus.m_paddr_i[m*AW +: AW]  = addr;
    bus.m_pwdata_i[m*32 +: 32] = data;
  endtask

  task automatic post_random(input int m);
    post_req(m, $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom_range(0, 1)));
  endtask

  function automatic int model_pick();
    for (int off = 1; off <= N; off++) begin
      if (pending[(last_owner + off) % N]) return (last_owner + off) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last_owner = N - 1;
    for (int m = 0; m < N; m++) pending[m] = 1'b0;
    bus.m_psel_i = '0;
  endtask

  // Called in IDLE, #1 after an edge, with this cycle's requests already posted.
  task automatic run_transfer(input int waits, input bit err, input logic [31:0] rd,
                              input bit scramble);
    int          w;
    logic [31:0] exp_addr, exp_data;
    logic        exp_wr;
    w = model_pick();
    if (w < 0) begin
      tick();
      check("idle_hold_psel", {bus.PSEL, bus.PENABLE}, 2'b00);
      check("idle_hold_grant", bus.grant_o, 0);
      return;
    end
    exp_addr = r_addr[w];
    exp_data = r_data[w];
    exp_wr   = r_wr[w];
    tick();
    check("setup_ctrl", {bus.PSEL, bus.PENABLE}, 2'b10);
    check("setup_grant", bus.grant_o, 64'(1) << w);
    check("setup_paddr", bus.PADDR, exp_addr);
    check("setup_pwdata", bus.PWDATA, exp_data);
    check("setup_pwrite", bus.PWRITE, exp_wr);
    check("setup_pready", bus.m_pready_o, 0);
    pending[w]      = 1'b0;
    bus.m_psel_i[w] = 1'b0;
    if (scramble) begin
      bus.m_paddr_i[w*AW +: AW]  = ~exp_addr;
      bus.m_pwdata_i[w*32 +: 32] = ~exp_data;
      bus.m_pwrite_i[w]          = ~exp_wr;
    end
    tick();
    for (int i = 0; i < waits; i++) begin
      bus.PREADY  = 1'b0;
      bus.PSLVERR = 1'($urandom_range(0, 1));
      #1;
      check("wait_ctrl", {bus.PSEL, bus.PENABLE}, 2'b11);
      check("wait_pready", bus.m_pready_o, 0);
      check("wait_pslverr", bus.m_pslverr_o, 0);
      check("wait_paddr", bus.PADDR, exp_addr);
      check("wait_timeout", bus.timeout_o, 0);
      if ($urandom_range(0, 3) == 0) begin
        int m;
        m = $urandom_range(0, N - 1);
        if (!pending[m]) post_random(m);
      end
      tick();
    end
    bus.PREADY  = 1'b1;
    bus.PSLVERR = err;
    bus.PRDATA  = rd;
    #1;
    check("done_ctrl", {bus.PSEL, bus.PENABLE}, 2'b11);
    check("done_pready", bus.m_pready_o, 64'(1) << w);
    check("done_pslverr", bus.m_pslverr_o, err ? (64'(1) << w) : 64'(0));
    check("done_prdata", bus.m_prdata_o, rd);
    check("done_paddr", bus.PADDR, exp_addr);
    check("done_pwdata", bus.PWDATA, exp_data);
    check("done_timeout", bus.timeout_o, 0);
    tick();
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    #1;
    check("after_ctrl", {bus.PSEL, bus.PENABLE}, 2'b00);
    check("after_grant", bus.grant_o, 0);
    check("after_pready", bus.m_pready_o, 0);
    last_owner = w;
  endtask

  initial begin
    ARESETn         = 1'b0;
    bus.m_psel_i    = '0;
    bus.m_penable_i = '0;
    bus.m_pwrite_i  = '0;
    bus.m_paddr_i   = '0;
    bus.m_pwdata_i  = '0;
    bus.PRDATA      = '0;
    bus.PREADY      = 1'b0;
    bus.PSLVERR     = 1'b0;
    model_reset();
    #1;
    check("rst_ctrl", {bus.PSEL, bus.PENABLE, bus.PWRITE}, 3'b000);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pwdata", bus.PWDATA, 0);
    check("rst_grant", bus.grant_o, 0);
    check("rst_pready", {bus.m_pready_o, bus.m_pslverr_o}, 0);
    check("rst_timeout", bus.timeout_o, 0);
    tick();
    tick();
    ARESETn = 1'b1;
    tick();

    // Single write from master 0 with zero wait states.
    post_req(0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
    run_transfer(0, 1'b0, 32'h0, 1'b0);

    // Master 1 read with 4 wait states; master 0 queues behind it and then
    // completes with an error. Both change their inputs after grant.
    post_req(1, 32'h0000_0020, 32'h0, 1'b0);
    post_req(0, 32'h0000_3000, 32'h1234_5678, 1'b1);
    run_transfer(4, 1'b0, 32'h55AA_55AA, 1'b1);
    run_transfer(1, 1'b1, 32'hCAFE_F00D, 1'b1);

    // Randomized traffic; first six transfers keep both requesters busy.
    for (int t = 0; t < 40; t++) begin
      for (int m = 0; m < N; m++) begin
        if (!pending[m] && (t < 6 || $urandom_range(0, 1) == 1)) post_random(m);
      end
      run_transfer((t < 6) ? 0 : int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                   $urandom, 1'($urandom_range(0, 1)));
    end
    // Drain anything still outstanding.
    for (int t = 0; t < N; t++) run_transfer(0, 1'b0, $urandom, 1'b0);

`ifdef APB_ARB_TIMEOUT_EN
    // Stalled completer: timeout after TMO ACCESS cycles.
    post_req(1, 32'h0000_0040, 32'h0, 1'b0);
    tick();
    check("tmo_grant", bus.grant_o, 2'b10);
    pending[1] = 1'b0;
    bus.m_psel_i[1] = 1'b0;
    tick();
    for (int i = 1; i < TMO; i++) begin
      check("tmo_wait_pready", bus.m_pready_o, 0);
      check("tmo_wait_pulse", bus.timeout_o, 0);
      tick();
    end
    check("tmo_pready", bus.m_pready_o, 2'b10);
    check("tmo_pslverr", bus.m_pslverr_o, 2'b10);
    check("tmo_pulse", bus.timeout_o, 1);
    tick();
    check("tmo_after_pulse", bus.timeout_o, 0);
    check("tmo_after_ctrl", {bus.PSEL, bus.PENABLE, bus.grant_o}, 0);
    last_owner = 1;

    // PREADY arriving in the limit cycle is a normal completion.
    post_req(0, 32'h0000_0044, 32'h0, 1'b0);
    tick();
    pending[0] = 1'b0;
    bus.m_psel_i[0] = 1'b0;
    tick();
    for (int i = 1; i < TMO; i++) tick();
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b0;
    #1;
    check("tmo_race_pready", bus.m_pready_o, 2'b01);
    check("tmo_race_pslverr", bus.m_pslverr_o, 0);
    check("tmo_race_pulse", bus.timeout_o, 0);
    tick();
    bus.PREADY = 1'b0;
    last_owner = 0;
    post_random(1);
    run_transfer(2, 1'b0, 32'h0BAD_CAFE, 1'b0);
`else
    // Without the timeout the arbiter waits indefinitely.
    post_random(0);
    run_transfer(300, 1'b0, 32'h1357_9BDF, 1'b0);
`endif

    // Reset while in ACCESS drops the bus at once.
    for (int m = 0; m < N; m++) if (!pending[m]) post_random(m);
    tick();
    bus.m_psel_i = '0;
    tick();
    check("pre_rst_ctrl", {bus.PSEL, bus.PENABLE}, 2'b11);
    bus.PREADY = 1'b1;
    ARESETn    = 1'b0;
    #1;
    check("mid_rst_ctrl", {bus.PSEL, bus.PENABLE}, 2'b00);
    check("mid_rst_grant", bus.grant_o, 0);
    check("mid_rst_pready", bus.m_pready_o, 0);
    tick();
    bus.PREADY = 1'b0;
    ARESETn    = 1'b1;
    model_reset();
    tick();
    for (int m = N - 1; m >= 0; m--) post_random(m);
    run_transfer(0, 1'b0, 32'h2468_ACE0, 1'b0);
    check("post_rst_last", last_owner, 0);
    run_transfer(0, 1'b0, 32'h1111_2222, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Round-robin arbiter that shares one APB3 completer bus between NUM_MASTERS APB requesters, for example an AXI-to-APB bridge and a debug/DMA APB master in the peripheral subsystem. It grants one requester at a time and latches its address, direction and write data at grant. It then runs a standard SETUP/ACCESS sequence downstream and routes PREADY/PSLVERR back to the granted requester only. Non-granted requesters see wait states until their turn.

## Interface
- NUM_MASTERS, 2, number of upstream APB requesters (2..8)
- APB_ADDR_WIDTH, 32, PADDR width
- TIMEOUT_CYCLES, 255, ACCESS-phase wait limit (used only with APB_ARB_TIMEOUT_EN; 1..65535)
- ACLK  input  1  clock
- ARESETn  input  1  asynchronous, active-low reset
- m_psel_i  input  NUM_MASTERS  per-requester transfer request
- m_penable_i  input  NUM_MASTERS  per-requester PENABLE; ignored by arbitration, kept for protocol completeness
- m_pwrite_i  input  NUM_MASTERS  per-requester direction
- m_paddr_i  input  NUM_MASTERS*APB_ADDR_WIDTH  packed addresses; requester i occupies slice [i*AW +: AW]
- m_pwdata_i  input  NUM_MASTERS*32  packed write data
- m_prdata_o  output  32  read data, broadcast to all requesters (direct PRDATA)
- m_pready_o  output  NUM_MASTERS  completion strobe, one-hot or zero
- m_pslverr_o  output  NUM_MASTERS  error, valid with m_pready_o
- PSEL, PENABLE, PWRITE  output  1  downstream APB control
- PADDR  output  APB_ADDR_WIDTH  downstream address
- PWDATA  output  32  downstream write data
- PRDATA  input  32  downstream read data
- PREADY, PSLVERR  input  1  downstream completion and error
- grant_o  output  NUM_MASTERS  one-hot current owner; zero in IDLE
- timeout_o  output  1  one-cycle pulse on a timed-out access; tied 0 without the macro

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - If any m_psel_i bit is set, pick the winner round-robin: the first set bit searched from (last_grant+1) mod N upward, wrapping.
  - Register grant, PADDR, PWRITE and PWDATA from the winner's slices, then go to SETUP.
  - With no requests, stay in IDLE.
- **SETUP**
  - PSEL=1, PENABLE=0. Unconditionally go to ACCESS.
- **ACCESS**
  - PSEL=1, PENABLE=1.
  - On PREADY=1: m_pready_o[winner]=1, m_pslverr_o[winner]=PSLVERR, last_grant←winner, go to IDLE.
  - Otherwise stay in ACCESS.
- Latched PADDR/PWDATA/PWRITE stay constant from SETUP through completion, even if the winner's inputs change. A requester dropping m_psel_i after grant does not abort the transfer.
- Non-granted requesters get m_pready_o=0 and m_pslverr_o=0 throughout.
- Requests arriving while the bus is busy are considered at the next IDLE.
- Fairness: no requester waits for more than N-1 other transfers.
- Reset (async, any state) puts the FSM in IDLE and last_grant=N-1, so master 0 wins first.
- Reset values of outputs: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, grant_o=0, m_pready_o=0, m_pslverr_o=0, timeout_o=0.
- m_prdata_o always follows PRDATA.
- A reset during ACCESS drops PSEL and PENABLE immediately. No m_pready_o is issued.

## Timing
- Request sampled in IDLE at cycle c: SETUP at c+1, ACCESS at c+2. With PREADY=1, m_pready_o pulses in c+2 (combinational from PREADY while in ACCESS).
- Minimum transfer: 3 cycles including IDLE. Back-to-back transfers take 3 cycles each.
- Each downstream wait state adds one cycle.
- The completing requester must sample m_prdata_o in the same cycle as m_pready_o.
- PSEL/PENABLE/PADDR/PWRITE/PWDATA/grant_o are register-driven (glitch-free).
- m_pready_o and m_pslverr_o are combinational from PREADY/PSLVERR gated by ACCESS and grant.

## Configuration
- Macro: APB_ARB_TIMEOUT_EN.
- **Defined**
  - A 16-bit counter clears on SETUP and increments each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES without PREADY: m_pready_o[winner]=1, m_pslverr_o[winner]=1, timeout_o=1 for one cycle, return to IDLE.
  - PREADY in the same cycle as the limit wins: normal completion, PSLVERR passed through, timeout_o=0.
- **Undefined**
  - No counter. ACCESS waits indefinitely. timeout_o is tied 0.

## Test plan
- Single request: master 0 writes 0xDEADBEEF to 0x1000, PREADY=1 immediately → PSEL at c+1, PENABLE at c+2, m_pready_o=2'b01 at c+2, PADDR=0x1000, PWDATA=0xDEADBEEF.
- Contention: both masters request continuously with 0 wait states → grants alternate 0,1,0,1; each completes every 3 cycles; grant_o never two-hot.
- Wait states plus read: master 1 reads 0x20 with PREADY low for 4 cycles and PRDATA=0x55AA55AA → m_pready_o=2'b10 at c+6 with m_prdata_o=0x55AA55AA; master 0 sees m_pready_o=0 throughout.
- Error and request stability: PSLVERR=1 on completion → m_pslverr_o set only for the winner. Master changes m_paddr_i during ACCESS → PADDR stays at the latched value.
- Reset mid-ACCESS: assert ARESETn=0 in ACCESS → PSEL=0, PENABLE=0, grant_o=0 immediately. After release, master 0 wins first.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: PREADY held 0 → m_pready_o and m_pslverr_o for the winner plus a timeout_o pulse after 8 ACCESS cycles. The next request is then served normally.
